// File: rtl/z2_cycle_ctrl_pkg.sv
// Shared constants for the Zorro II slave-cycle controller: state encoding
// and the timeout counter width helper.
package z2_cycle_ctrl_pkg;

    localparam int Z2_STATE_W = 3;

    typedef enum logic [Z2_STATE_W-1:0] {
        Z2_IDLE    = 3'd0,
        Z2_START   = 3'd1,
        Z2_DATA    = 3'd2,
        Z2_END     = 3'd3,
        Z2_TIMEOUT = 3'd4
    } z2_state_e;

    // Counter must hold TIMEOUT_CYCLES; a disabled timeout still gets one bit.
    function automatic int timer_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/z2_sync.sv
// Multi-flop synchroniser for one raw 68k strobe; idles high (negated) in reset.
module z2_sync #(
    parameter int STAGES = 2
) (
    input  logic MEMCLK,
    input  logic RESET_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sync_q <= {STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/z2_cycle_ctrl.sv
// Zorro II slave-cycle controller: strobe synchronisation, slave arbitration,
// IDLE/START/DATA/END handshake with DTACK, timeout and bus-error abort.
module z2_cycle_ctrl
    import z2_cycle_ctrl_pkg::*;
#(
    parameter int NUM_SLAVES     = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  MEMCLK,
    input  logic                  RESET_n,
    input  logic                  AS_n,
    input  logic                  UDS_n,
    input  logic                  LDS_n,
    input  logic                  RW,
    input  logic                  BERR_n,
    input  logic [NUM_SLAVES-1:0] slave_sel,
    input  logic [NUM_SLAVES-1:0] slave_ack,
    input  logic                  err_clr,
    output logic                  as_n_s,
    output logic                  uds_n_s,
    output logic                  lds_n_s,
    output logic                  rw_s,
    output logic [Z2_STATE_W-1:0] z2_state,
    output logic [NUM_SLAVES-1:0] owner,
    output logic                  dtack,
    output logic                  ovr,
    output logic                  timeout_pulse,
    output logic                  timeout_sticky
);

    localparam int              TMR_W   = timer_width(TIMEOUT_CYCLES);
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};
    localparam logic [TMR_W-1:0] TO_LAST = TO_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : {TMR_W{1'b0}};

    logic             berr_n_s;
    logic             as_early_q;
    z2_state_e        state_q;
    logic [NUM_SLAVES-1:0] owner_q;
    logic             dtack_q;
    logic [TMR_W-1:0] timer_q;
    logic             pulse_q;
    logic             sticky_q;
    logic [TMR_W-1:0] timer_inc_s;
    logic             timeout_hit_s;

    // Lowest-index decoder hit wins arbitration.
    function automatic logic [NUM_SLAVES-1:0] lowest_set(input logic [NUM_SLAVES-1:0] v);
        logic [NUM_SLAVES-1:0] r;
        r = {NUM_SLAVES{1'b0}};
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = {NUM_SLAVES{1'b0}};
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    z2_sync #(.STAGES(SYNC_STAGES)) u_sync_as   (.MEMCLK(MEMCLK), .RESET_n(RESET_n), .d_i(AS_n),   .q_o(as_n_s));
    z2_sync #(.STAGES(SYNC_STAGES)) u_sync_uds  (.MEMCLK(MEMCLK), .RESET_n(RESET_n), .d_i(UDS_n),  .q_o(uds_n_s));
    z2_sync #(.STAGES(SYNC_STAGES)) u_sync_lds  (.MEMCLK(MEMCLK), .RESET_n(RESET_n), .d_i(LDS_n),  .q_o(lds_n_s));
    z2_sync #(.STAGES(SYNC_STAGES)) u_sync_rw   (.MEMCLK(MEMCLK), .RESET_n(RESET_n), .d_i(RW),     .q_o(rw_s));
    z2_sync #(.STAGES(SYNC_STAGES)) u_sync_berr (.MEMCLK(MEMCLK), .RESET_n(RESET_n), .d_i(BERR_n), .q_o(berr_n_s));

    assign timer_inc_s   = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    assign timeout_hit_s = TO_EN && (timer_q == TO_LAST);

    // Extra AS stage: starting a cycle one flop late guarantees as_n_s is already low in START.
    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            as_early_q <= 1'b1;
        end else begin
            as_early_q <= as_n_s;
        end
    end

    // Handshake FSM with registered DTACK, owner, timer and timeout flags.
    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= Z2_IDLE;
            owner_q  <= {NUM_SLAVES{1'b0}};
            dtack_q  <= 1'b0;
            timer_q  <= {TMR_W{1'b0}};
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (err_clr) begin
                sticky_q <= 1'b0;
            end
            case (state_q)
                Z2_IDLE: begin
                    dtack_q <= 1'b0;
                    timer_q <= {TMR_W{1'b0}};
                    if (!as_early_q && (|slave_sel)) begin
                        state_q <= Z2_START;
                        owner_q <= lowest_set(slave_sel);
                    end else begin
                        owner_q <= {NUM_SLAVES{1'b0}};
                    end
                end
                Z2_START: begin
                    timer_q <= timer_inc_s;
                    if (as_n_s) begin
                        state_q <= Z2_IDLE;
                        owner_q <= {NUM_SLAVES{1'b0}};
                    end else if (timeout_hit_s) begin
                        state_q  <= Z2_TIMEOUT;
                        pulse_q  <= 1'b1;
                        sticky_q <= 1'b1;
                    end else if (!uds_n_s || !lds_n_s) begin
                        state_q <= Z2_DATA;
                    end
                end
                Z2_DATA: begin
                    timer_q <= timer_inc_s;
                    if (!berr_n_s) begin
                        state_q <= Z2_END;
                    end else if (|(slave_ack & owner_q)) begin
                        dtack_q <= 1'b1;
                        state_q <= Z2_END;
                    end else if (timeout_hit_s) begin
                        state_q  <= Z2_TIMEOUT;
                        pulse_q  <= 1'b1;
                        sticky_q <= 1'b1;
                    end
                end
                Z2_END: begin
                    if (as_n_s) begin
                        dtack_q <= 1'b0;
                        owner_q <= {NUM_SLAVES{1'b0}};
                        state_q <= Z2_IDLE;
                    end
                end
                Z2_TIMEOUT: begin
                    dtack_q <= 1'b0;
                    if (as_n_s) begin
                        owner_q <= {NUM_SLAVES{1'b0}};
                        state_q <= Z2_IDLE;
                    end
                end
                default: begin
                    state_q <= Z2_IDLE;
                    owner_q <= {NUM_SLAVES{1'b0}};
                    dtack_q <= 1'b0;
                    timer_q <= {TMR_W{1'b0}};
                end
            endcase
        end
    end

    assign z2_state       = state_q;
    assign owner          = owner_q;
    assign dtack          = dtack_q;
    assign timeout_pulse  = pulse_q;
    assign timeout_sticky = sticky_q;
    assign ovr            = (|slave_sel) && !AS_n;

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// Directed scenarios plus randomized bus cycles, checked every clock against a
// behavioural model of the Zorro II slave handshake.
module tb_z2_cycle_ctrl;

    localparam int S_IDLE = 0, S_START = 1, S_DATA = 2, S_END = 3, S_TO = 4;
    localparam int TO   = 8;
    localparam int TMAX = 15;

    logic       MEMCLK = 1'b0;
    logic       RESET_n, AS_n, UDS_n, LDS_n, RW, BERR_n, err_clr;
    logic [4:0] slave_sel, slave_ack;
    logic       as_n_s, uds_n_s, lds_n_s, rw_s;
    logic [2:0] z2_state;
    logic [4:0] owner;
    logic       dtack, ovr, timeout_pulse, timeout_sticky;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [2:0] h_as;
    logic [1:0] h_uds, h_lds, h_rw, h_berr;
    int         m_st, m_cnt;
    logic [4:0] m_owner;
    logic       m_dtack, m_pulse, m_sticky;

    z2_cycle_ctrl #(.NUM_SLAVES(5), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .MEMCLK(MEMCLK), .RESET_n(RESET_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .RW(RW), .BERR_n(BERR_n), .slave_sel(slave_sel), .slave_ack(slave_ack),
        .err_clr(err_clr), .as_n_s(as_n_s), .uds_n_s(uds_n_s), .lds_n_s(lds_n_s),
        .rw_s(rw_s), .z2_state(z2_state), .owner(owner), .dtack(dtack), .ovr(ovr),
        .timeout_pulse(timeout_pulse), .timeout_sticky(timeout_sticky)
    );

    always #5 MEMCLK = ~MEMCLK;

    task automatic model_reset();
        h_as = 3'b111; h_uds = 2'b11; h_lds = 2'b11; h_rw = 2'b11; h_berr = 2'b11;
        m_st = S_IDLE; m_cnt = 0; m_owner = 5'd0;
        m_dtack = 1'b0; m_pulse = 1'b0; m_sticky = 1'b0;
    endtask

    // One MEMCLK edge of the handshake rules, using the inputs present before the edge.
    task automatic model_step();
        logic as_e, as_s, ds_s, berr_s, hit;
        logic [4:0] low;
        int nxt;
        if (!RESET_n) begin
            model_reset();
            return;
        end
        as_e   = h_as[2];
        as_s   = h_as[1];
        ds_s   = !h_uds[1] || !h_lds[1];
        berr_s = h_berr[1];
        hit    = (m_cnt == TO - 1);
        nxt    = (m_cnt < TMAX) ? m_cnt + 1 : TMAX;
        low    = slave_sel & (~slave_sel + 5'd1);
        m_pulse = 1'b0;
        if (err_clr) m_sticky = 1'b0;
        case (m_st)
            S_IDLE: begin
                m_dtack = 1'b0; m_cnt = 0;
                if (!as_e && slave_sel != 5'd0) begin m_st = S_START; m_owner = low; end
            end
            S_START: begin
                m_cnt = nxt;
                if (as_s) begin m_st = S_IDLE; m_owner = 5'd0; end
                else if (hit) begin m_st = S_TO; m_pulse = 1'b1; m_sticky = 1'b1; end
                else if (ds_s) m_st = S_DATA;
            end
            S_DATA: begin
                m_cnt = nxt;
                if (!berr_s) m_st = S_END;
                else if ((slave_ack & m_owner) != 5'd0) begin m_dtack = 1'b1; m_st = S_END; end
                else if (hit) begin m_st = S_TO; m_pulse = 1'b1; m_sticky = 1'b1; end
            end
            S_END: if (as_s) begin m_dtack = 1'b0; m_owner = 5'd0; m_st = S_IDLE; end
            S_TO: begin
                m_dtack = 1'b0;
                if (as_s) begin m_owner = 5'd0; m_st = S_IDLE; end
            end
            default: ;
        endcase
        h_as   = {h_as[1:0], AS_n};
        h_uds  = {h_uds[0], UDS_n};
        h_lds  = {h_lds[0], LDS_n};
        h_rw   = {h_rw[0], RW};
        h_berr = {h_berr[0], BERR_n};
    endtask

    task automatic check_all();
        logic [3:0] want_sync;
        logic [10:0] want_ctl;
        logic [2:0] st3;
        st3 = m_st[2:0];
        want_sync = {h_as[1], h_uds[1], h_lds[1], h_rw[1]};
        want_ctl  = {st3, m_owner, m_dtack, m_pulse, m_sticky};
        n_assert++;
        assert ({as_n_s, uds_n_s, lds_n_s, rw_s} === want_sync) else begin
            n_fail++;
            $error("FAIL sync at %0t: got %b want %b", $time, {as_n_s, uds_n_s, lds_n_s, rw_s}, want_sync);
        end
        n_assert++;
        assert ({z2_state, owner, dtack, timeout_pulse, timeout_sticky} === want_ctl) else begin
            n_fail++;
            $error("FAIL ctl {state,owner,dtack,pulse,sticky} at %0t: got %b want %b", $time,
                   {z2_state, owner, dtack, timeout_pulse, timeout_sticky}, want_ctl);
        end
        n_assert++;
        assert (ovr === ((slave_sel != 5'd0) && !AS_n)) else begin
            n_fail++;
            $error("FAIL ovr at %0t: got %b want %b", $time, ovr, (slave_sel != 5'd0) && !AS_n);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge MEMCLK);
        #1;
        check_all();
    endtask

    task automatic expect_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int k = 0;
        while (z2_state !== st && k < budget) begin tick(); k++; end
        n_assert++;
        assert (z2_state === st) else begin
            n_fail++;
            $error("FAIL %s: state %0d want %0d after %0d cycles", tag, z2_state, st, k);
        end
    endtask

    task automatic wait_dtack(input int budget, input string tag);
        int k = 0;
        while (dtack !== 1'b1 && k < budget) begin tick(); k++; end
        n_assert++;
        assert (dtack === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: dtack %b want 1 after %0d cycles", tag, dtack, k);
        end
    endtask

    task automatic release_bus();
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; BERR_n = 1'b1;
        slave_sel = 5'd0; slave_ack = 5'd0; err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int enter, pulses, k;
        logic dseen, st_sticky;
        logic [4:0] sel_r;
        logic [1:0] ds_r;
        bit abort, berr;
        int dly;

        RESET_n = 1'b1; RW = 1'b1;
        release_bus();
        model_reset();
        #1 RESET_n = 1'b0;
        #1 check_all();
        expect_val("reset_state", {5'd0, z2_state}, 8'd0);
        repeat (3) tick();
        RESET_n = 1'b1;
        repeat (3) tick();

        // Read cycle to slave 2
        AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; slave_sel = 5'b00100;
        wait_state(3'(S_START), 8, "read_start");
        expect_val("read_owner", {3'd0, owner}, 8'h04);
        repeat (4) tick();
        slave_ack = 5'b00100;
        wait_dtack(4, "read_dtack");
        expect_val("read_end", {5'd0, z2_state}, 8'(S_END));
        release_bus();
        wait_state(3'(S_IDLE), 4, "read_idle");
        expect_val("read_idle_dtack", {7'd0, dtack}, 8'd0);
        repeat (2) tick();

        // Multi-hit arbitration, non-owner ack ignored
        AS_n = 1'b0; LDS_n = 1'b0; RW = 1'b0; slave_sel = 5'b01010;
        wait_state(3'(S_START), 8, "multi_start");
        expect_val("multi_owner", {3'd0, owner}, 8'h02);
        slave_sel = 5'b10000; slave_ack = 5'b10000;
        repeat (4) tick();
        expect_val("multi_no_dtack", {7'd0, dtack}, 8'd0);
        expect_val("multi_owner_held", {3'd0, owner}, 8'h02);
        slave_ack = 5'b00010;
        wait_dtack(3, "multi_dtack");
        release_bus();
        wait_state(3'(S_IDLE), 4, "multi_idle");
        repeat (2) tick();

        // Timeout with err_clr held: set wins on the timeout edge, clear the edge after
        AS_n = 1'b0; UDS_n = 1'b0; slave_sel = 5'b00001; err_clr = 1'b1;
        wait_state(3'(S_START), 8, "to_start");
        enter = -1; pulses = 0; dseen = 1'b0; st_sticky = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            pulses += int'(timeout_pulse);
            dseen |= dtack;
            if (z2_state == 3'(S_TO) && enter < 0) begin enter = i; st_sticky = timeout_sticky; end
        end
        expect_val("to_latency", 8'(enter), 8'd8);
        expect_val("to_pulses", 8'(pulses), 8'd1);
        expect_val("to_sticky_set", {7'd0, st_sticky}, 8'd1);
        expect_val("to_no_dtack", {7'd0, dseen}, 8'd0);
        expect_val("to_sticky_cleared", {7'd0, timeout_sticky}, 8'd0);
        release_bus();
        wait_state(3'(S_IDLE), 4, "to_idle");
        repeat (2) tick();

        // BERR and ack reach the FSM together
        AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; slave_sel = 5'b00001;
        wait_state(3'(S_DATA), 8, "berr_data");
        BERR_n = 1'b0;
        tick(); tick();
        slave_ack = 5'b00001;
        tick();
        expect_val("berr_end", {5'd0, z2_state}, 8'(S_END));
        expect_val("berr_no_dtack", {7'd0, dtack}, 8'd0);
        release_bus();
        wait_state(3'(S_IDLE), 4, "berr_idle");
        repeat (2) tick();

        // Aborted cycle in START
        AS_n = 1'b0; slave_sel = 5'b01000;
        wait_state(3'(S_START), 8, "abort_start");
        AS_n = 1'b1;
        repeat (3) tick();
        expect_val("abort_idle", {5'd0, z2_state}, 8'(S_IDLE));
        expect_val("abort_owner", {3'd0, owner}, 8'd0);
        release_bus();
        repeat (2) tick();

        // Asynchronous reset while DTACK is held
        AS_n = 1'b0; UDS_n = 1'b0; slave_sel = 5'b00100; slave_ack = 5'b00100;
        wait_dtack(10, "rst_dtack");
        #2 RESET_n = 1'b0;
        #1 model_reset();
        check_all();
        expect_val("rst_async", {dtack, owner, z2_state[1:0]}, 8'd0);
        release_bus();
        tick(); tick();
        RESET_n = 1'b1;
        repeat (3) tick();
        AS_n = 1'b0; UDS_n = 1'b0; slave_sel = 5'b00100; slave_ack = 5'b00100;
        wait_dtack(10, "rst_next_dtack");
        release_bus();
        wait_state(3'(S_IDLE), 4, "rst_next_idle");
        repeat (2) tick();

        // Randomized cycles against the model
        for (int t = 0; t < 40; t++) begin
            sel_r = 5'($urandom_range(0, 31));
            ds_r  = 2'($urandom_range(1, 3));
            abort = ($urandom_range(0, 7) == 0);
            berr  = ($urandom_range(0, 7) == 0);
            dly   = $urandom_range(0, 10);
            AS_n = 1'b0; RW = 1'($urandom_range(0, 1)); slave_sel = sel_r;
            if (!abort) begin UDS_n = !ds_r[1]; LDS_n = !ds_r[0]; end
            for (int d = 0; d < dly; d++) begin
                err_clr = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) slave_sel = 5'($urandom_range(0, 31));
                tick();
            end
            err_clr = 1'b0;
            if (abort) begin
                AS_n = 1'b1;
            end else begin
                if (berr) BERR_n = 1'b0;
                slave_ack = 5'($urandom_range(0, 31));
                k = 0;
                while (k < 12 && z2_state != 3'(S_END) && z2_state != 3'(S_TO) && z2_state != 3'(S_IDLE)) begin
                    tick(); k++;
                end
            end
            tick();
            release_bus();
            repeat ($urandom_range(4, 6)) tick();
        end
        wait_state(3'(S_IDLE), 16, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
